// File: rtl/lockin_cic_decimator.sv
// -----------------------------------------------------------------------------
// lockin_cic_decimator
//
// Dual-channel (phase / quadrature) CIC decimator that sits behind the lock-in
// mixer. Each BUFFER_DEPTH-sample frame is filtered on its own: the integrators
// restart on the sample with address 0, and the first comb token of a frame
// ignores the comb delay registers. The result is divided by R^N, which gives
// unity DC gain and floor rounding.
//
// Ports
//   clk                in  system clock, rising edge
//   reset              in  synchronous, active-low reset
//   cic_phase_in       in  signed phase mixer product        [IN_WIDTH]
//   cic_quadrature_in  in  signed quadrature mixer product   [IN_WIDTH]
//   cic_addr_in        in  sample index within the frame     [log2(BUFFER_DEPTH)]
//   cic_valid_in       in  one-cycle strobe per input sample
//   phase_out          out signed decimated phase            [IN_WIDTH]
//   quadrature_out     out signed decimated quadrature       [IN_WIDTH]
//   out_valid          out one-cycle output strobe
//   out_index          out decimated index within the frame  [log2(BUFFER_DEPTH/R)]
//   frame_done         out high with out_valid on the last output of a frame
//   seq_error          out sticky flag for a broken address sequence
// -----------------------------------------------------------------------------
module lockin_cic_decimator #(
  parameter  int BUFFER_DEPTH = 512,
  parameter  int IN_WIDTH     = 42,
  parameter  int N_STAGES     = 3,
  parameter  int DECIM_LOG2   = 4,
  localparam int ADDR_W       = $clog2(BUFFER_DEPTH),
  localparam int N_OUT        = BUFFER_DEPTH >> DECIM_LOG2,
  localparam int IDX_W        = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [IN_WIDTH-1:0] cic_phase_in,
  input  logic signed [IN_WIDTH-1:0] cic_quadrature_in,
  input  logic        [ADDR_W-1:0]   cic_addr_in,
  input  logic                       cic_valid_in,
  output logic signed [IN_WIDTH-1:0] phase_out,
  output logic signed [IN_WIDTH-1:0] quadrature_out,
  output logic                       out_valid,
  output logic        [IDX_W-1:0]    out_index,
  output logic                       frame_done,
  output logic                       seq_error
);

  localparam int SHIFT = N_STAGES * DECIM_LOG2;
  localparam int ACC_W = IN_WIDTH + SHIFT;

  // ---------------------------------------------------------------------------
  // Frame / decimation control, shared by both channels
  // ---------------------------------------------------------------------------
  logic w_frame_start;
  logic w_launch;
  logic w_last;

  logic [DECIM_LOG2-1:0] r_dec_cnt;
  logic [IDX_W-1:0]      r_dec_idx;
  logic                  r_first_pend;
  logic [ADDR_W-1:0]     r_prev_addr;
  logic                  r_seq_err;

  // Token pipeline: entry s marks that comb stage s holds work this cycle.
  logic             r_tv [N_STAGES];
  logic             r_tf [N_STAGES];
  logic             r_tl [N_STAGES];
  logic [IDX_W-1:0] r_ti [N_STAGES];

  logic             r_out_valid;
  logic             r_frame_done;
  logic [IDX_W-1:0] r_out_index;

  assign w_frame_start = cic_valid_in && (cic_addr_in == '0);
  // The frame-start sample reloads the counter, so it never fires a decimation.
  assign w_launch      = cic_valid_in && !w_frame_start &&
                         (r_dec_cnt == {DECIM_LOG2{1'b1}});
  assign w_last        = (cic_addr_in == ADDR_W'(BUFFER_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dec_cnt    <= '0;
      r_dec_idx    <= '0;
      r_first_pend <= 1'b0;
      r_prev_addr  <= '0;
      r_seq_err    <= 1'b0;
      for (int s = 0; s < N_STAGES; s++) begin
        r_tv[s] <= 1'b0;
        r_tf[s] <= 1'b0;
        r_tl[s] <= 1'b0;
        r_ti[s] <= '0;
      end
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_index  <= '0;
    end else begin
      if (cic_valid_in) begin
        r_prev_addr <= cic_addr_in;
        if (w_frame_start) begin
          r_dec_cnt    <= DECIM_LOG2'(1);
          r_dec_idx    <= '0;
          r_first_pend <= 1'b1;
          r_seq_err    <= 1'b0;
        end else begin
          r_dec_cnt <= r_dec_cnt + 1'b1;
          if (cic_addr_in != ADDR_W'(r_prev_addr + 1'b1)) begin
            r_seq_err <= 1'b1;
          end
          if (w_launch) begin
            r_first_pend <= 1'b0;
            r_dec_idx    <= r_dec_idx + 1'b1;
          end
        end
      end

      r_tv[0] <= w_launch;
      if (w_launch) begin
        r_tf[0] <= r_first_pend;
        r_tl[0] <= w_last;
        r_ti[0] <= r_dec_idx;
      end
      for (int s = 1; s < N_STAGES; s++) begin
        r_tv[s] <= r_tv[s-1];
        r_tf[s] <= r_tf[s-1];
        r_tl[s] <= r_tl[s-1];
        r_ti[s] <= r_ti[s-1];
      end

      r_out_valid  <= r_tv[N_STAGES-1];
      r_frame_done <= r_tv[N_STAGES-1] && r_tl[N_STAGES-1];
      if (r_tv[N_STAGES-1]) begin
        r_out_index <= r_ti[N_STAGES-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: channel 0 = phase, channel 1 = quadrature
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic signed [IN_WIDTH-1:0] w_in;
      logic signed [ACC_W-1:0]    w_x;
      logic signed [ACC_W-1:0]    r_int  [N_STAGES];
      logic signed [ACC_W-1:0]    r_z    [N_STAGES];
      logic signed [ACC_W-1:0]    r_y    [N_STAGES-1];
      logic signed [ACC_W-1:0]    w_cin  [N_STAGES];
      logic signed [ACC_W-1:0]    w_diff [N_STAGES];
      logic signed [IN_WIDTH-1:0] r_out;

      if (gi == 0) begin : g_sel_p
        assign w_in = cic_phase_in;
      end else begin : g_sel_q
        assign w_in = cic_quadrature_in;
      end

      assign w_x = {{SHIFT{w_in[IN_WIDTH-1]}}, w_in};

      // The last integrator's register is the comb input directly: the token
      // launched at edge k reads it at edge k+1, when it still holds the
      // value written at edge k.
      always_comb begin
        w_cin[0] = r_int[N_STAGES-1];
        for (int s = 1; s < N_STAGES; s++) begin
          w_cin[s] = r_y[s-1];
        end
        for (int s = 0; s < N_STAGES; s++) begin
          // The first token of a frame must not see the previous frame's delay.
          w_diff[s] = w_cin[s] - (r_tf[s] ? '0 : r_z[s]);
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < N_STAGES; k++) begin
            r_int[k] <= '0;
            r_z[k]   <= '0;
          end
          for (int k = 0; k < N_STAGES - 1; k++) begin
            r_y[k] <= '0;
          end
          r_out <= '0;
        end else begin
          if (cic_valid_in) begin
            if (w_frame_start) begin
              r_int[0] <= w_x;
              for (int k = 1; k < N_STAGES; k++) begin
                r_int[k] <= '0;
              end
            end else begin
              r_int[0] <= r_int[0] + w_x;
              for (int k = 1; k < N_STAGES; k++) begin
                r_int[k] <= r_int[k] + r_int[k-1];
              end
            end
          end

          for (int s = 0; s < N_STAGES; s++) begin
            if (r_tv[s]) begin
              r_z[s] <= w_cin[s];
            end
          end
          for (int s = 0; s < N_STAGES - 1; s++) begin
            if (r_tv[s]) begin
              r_y[s] <= w_diff[s];
            end
          end
          // Division by R^N with floor rounding; the wrapped accumulator
          // difference is exact, so the top IN_WIDTH bits are the result.
          if (r_tv[N_STAGES-1]) begin
            r_out <= IN_WIDTH'(w_diff[N_STAGES-1] >>> SHIFT);
          end
        end
      end
    end
  endgenerate

  assign phase_out      = g_ch[0].r_out;
  assign quadrature_out = g_ch[1].r_out;
  assign out_valid      = r_out_valid;
  assign out_index      = r_out_index;
  assign frame_done     = r_frame_done;
  assign seq_error      = r_seq_err;

endmodule

// File: tb/tb_lockin_cic_decimator.sv
module tb_lockin_cic_decimator;

  localparam int IW = 42;
  localparam int AW = 9;
  localparam int XW = 5;
  localparam int NOUT = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic signed [IW-1:0] ph_in, qd_in;
  logic        [AW-1:0] addr_in;
  logic                 valid_in;
  logic signed [IW-1:0] ph_out, qd_out;
  logic                 out_valid;
  logic        [XW-1:0] out_index;
  logic                 frame_done, seq_error;

  always #5 clk = ~clk;

  lockin_cic_decimator dut (
    .clk              (clk),
    .reset            (reset),
    .cic_phase_in     (ph_in),
    .cic_quadrature_in(qd_in),
    .cic_addr_in      (addr_in),
    .cic_valid_in     (valid_in),
    .phase_out        (ph_out),
    .quadrature_out   (qd_out),
    .out_valid        (out_valid),
    .out_index        (out_index),
    .frame_done       (frame_done),
    .seq_error        (seq_error)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint p;
    longint q;
    int     idx;
    bit     done;
    int     cyc;
  } cap_t;
  cap_t cap[$];

  always @(negedge clk) begin
    cap_t c;
    if (out_valid) begin
      c.p = ph_out;
      c.q = qd_out;
      c.idx = int'(out_index);
      c.done = frame_done;
      c.cyc = cyc;
      cap.push_back(c);
      $display("out: idx=%0d phase=%0d quad=%0d done=%0b cycle=%0d", out_index, ph_out, qd_out, frame_done, cyc);
    end
    if (frame_done && !out_valid) begin
      n_err++;
      $display("FAIL frame_done_strobe: frame_done=1 with out_valid=0 at cycle %0d, required 0", cyc);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Frame table: input constants, gap pattern, and hand-computed outputs.
  // e0*/e1* are the settling outputs at index 0/1 (560x/4096, 3280x/4096 floored).
  typedef struct {
    longint p;
    longint q;
    int     max_gap;
    bit     chain;
    bit     early;
    longint e0p, e0q, e1p, e1q;
  } frame_t;

  localparam int NT = 5;
  frame_t tbl[NT];
  int     t15s[NT];

  task automatic drive_rand_idle();
    valid_in = 1'b0;
    ph_in    = IW'({$urandom(), $urandom()});
    qd_in    = IW'({$urandom(), $urandom()});
    addr_in  = AW'($urandom());
  endtask

  task automatic send(input longint p, input longint q, input int a);
    @(negedge clk);
    ph_in    = IW'(p);
    qd_in    = IW'(q);
    addr_in  = AW'(a);
    valid_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_rand_idle();
    end
  endtask

  task automatic run_frame(input frame_t f, output int t15);
    int g;
    t15 = 0;
    for (int a = 0; a < 512; a++) begin
      send(f.p, f.q, a);
      if (a == 15) t15 = cyc;
      g = (f.max_gap > 0) ? int'($urandom_range(f.max_gap, 0)) : 0;
      idle(g);
    end
  endtask

  task automatic check_frame(input int fi, input frame_t f, input int base, input int t15);
    if (base >= cap.size()) begin
      n_vec++;
      n_err++;
      $display("FAIL f%0d_present: got %0d outputs, required at least %0d", fi, cap.size(), base + 1);
      return;
    end
    chk($sformatf("f%0d_latency", fi), cap[base].cyc, t15 + 4);
    for (int j = 0; j < NOUT; j++) begin
      if (base + j < cap.size()) begin
        chk($sformatf("f%0d_o%0d_index", fi, j), cap[base+j].idx, j);
        chk($sformatf("f%0d_o%0d_done", fi, j), cap[base+j].done, (j == NOUT - 1) ? 1 : 0);
        if (j >= 2) begin
          chk($sformatf("f%0d_o%0d_phase", fi, j), cap[base+j].p, f.p);
          chk($sformatf("f%0d_o%0d_quad", fi, j), cap[base+j].q, f.q);
        end else if (f.early) begin
          chk($sformatf("f%0d_o%0d_phase", fi, j), cap[base+j].p, (j == 0) ? f.e0p : f.e1p);
          chk($sformatf("f%0d_o%0d_quad", fi, j), cap[base+j].q, (j == 0) ? f.e0q : f.e1q);
        end
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_phase"}, ph_out, 0);
    chk({tag, "_quad"}, qd_out, 0);
    chk({tag, "_index"}, out_index, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_seq_error"}, seq_error, 0);
  endtask

  int rst_pts[2];
  int gstart;
  int t_full;
  bit end_grp;

  initial begin
    tbl[0] = '{1000, -500, 0, 1'b0, 1'b1, 136, -69, 800, -401};
    tbl[1] = '{1000, -500, 7, 1'b0, 1'b1, 136, -69, 800, -401};
    tbl[2] = '{1000, -500, 0, 1'b0, 1'b1, 136, -69, 800, -401};
    tbl[3] = '{0, 0, 0, 1'b1, 1'b1, 0, 0, 0, 0};
    tbl[4] = '{-(longint'(1) << 41), (longint'(1) << 41) - 1, 3, 1'b0, 1'b0, 0, 0, 0, 0};
    rst_pts[0] = 97;
    rst_pts[1] = 100;

    // Reset with toggling inputs.
    reset = 1'b0;
    drive_rand_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_rand_idle();
      valid_in = 1'($urandom());
      chk_outputs_zero($sformatf("reset_c%0d", i));
    end
    @(negedge clk);
    drive_rand_idle();
    reset = 1'b1;
    idle(4);

    // Table-driven frames; chained entries follow the previous frame directly.
    gstart = 0;
    for (int i = 0; i < NT; i++) begin
      if (!tbl[i].chain) begin
        cap.delete();
        gstart = i;
      end
      run_frame(tbl[i], t15s[i]);
      end_grp = (i == NT - 1) ? 1'b1 : !tbl[i+1].chain;
      if (end_grp) begin
        idle(10);
        chk($sformatf("grp%0d_out_count", gstart), cap.size(), NOUT * (i - gstart + 1));
        for (int k = gstart; k <= i; k++) begin
          check_frame(k, tbl[k], (k - gstart) * NOUT, t15s[k]);
        end
      end
    end

    // Address sequence error: 0..5 then 7.
    for (int a = 0; a <= 5; a++) send(7, 7, a);
    @(negedge clk);
    chk("seq_before_skip", seq_error, 0);
    ph_in = 7; qd_in = 7; addr_in = 9'd7; valid_in = 1'b1;
    @(negedge clk);
    drive_rand_idle();
    chk("seq_set", seq_error, 1);
    idle(3);
    chk("seq_hold_idle", seq_error, 1);
    send(7, 7, 8);
    send(7, 7, 9);
    idle(1);
    chk("seq_hold_valid", seq_error, 1);
    send(7, 7, 0);
    idle(1);
    chk("seq_clear", seq_error, 0);
    idle(8);

    // Mid-frame reset, then R samples needed before the next strobe.
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < rst_pts[r]; a++) send(1000, -500, a);
      @(negedge clk);
      ph_in = 1000; qd_in = -500; addr_in = AW'(rst_pts[r]); valid_in = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        drive_rand_idle();
        chk_outputs_zero($sformatf("midrst%0d_c%0d", rst_pts[r], i));
      end
      reset = 1'b1;
      cap.delete();
      idle(8);
      chk($sformatf("midrst%0d_no_stale", rst_pts[r]), cap.size(), 0);
      for (int a = 1; a <= 15; a++) send(1000, -500, rst_pts[r] + a);
      idle(8);
      chk($sformatf("midrst%0d_15_samples", rst_pts[r]), cap.size(), 0);
      send(1000, -500, rst_pts[r] + 16);
      idle(8);
      chk($sformatf("midrst%0d_16_samples", rst_pts[r]), cap.size(), 1);

      cap.delete();
      run_frame(tbl[0], t_full);
      idle(10);
      chk($sformatf("postrst%0d_out_count", rst_pts[r]), cap.size(), NOUT);
      check_frame(10 + r, tbl[0], 0, t_full);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
